// File: rtl/fir_xifu_pkg.sv
// Shared types and sizing for the FIR extension unit X-interface (core side).
package fir_xifu_pkg;

  localparam int X_ID_WIDTH = 4;
  localparam int X_ID_MAX   = 2 ** X_ID_WIDTH;

  typedef enum logic [1:0] {
    ID_FREE     = 2'd0,
    ID_RESERVED = 2'd1,
    ID_INFLIGHT = 2'd2
  } id_state_t;

  typedef struct packed {
    logic [31:0]           instr;
    logic [31:0]           rs1;
    logic [31:0]           rs2;
    logic                  kill;
    logic [X_ID_WIDTH-1:0] id;
  } offload_req_t;

endpackage

// File: rtl/fir_xif_id_alloc.sv
// X-interface ID tracker: per-ID FREE/RESERVED/INFLIGHT state, lowest-free
// allocation from the registered state vector, and a count of busy IDs.
module fir_xif_id_alloc #(
  parameter int X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reserve_i,
  output logic                  free_valid_o,
  output logic [X_ID_WIDTH-1:0] free_id_o,
  input  logic                  commit_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_inflight_i,
  input  logic                  result_free_i,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  input  logic [X_ID_WIDTH-1:0] query_id_i,
  output logic                  query_inflight_o,
  output logic [X_ID_WIDTH:0]   count_o
);
  import fir_xifu_pkg::*;

  localparam int ID_NUM = 2 ** X_ID_WIDTH;

  id_state_t state_q [ID_NUM];

  // Reserve, commit-resolve and result-free target distinct IDs, so all apply together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ID_NUM; i++) state_q[i] <= ID_FREE;
    end else begin
      if (reserve_i)     state_q[free_id_o]   <= ID_RESERVED;
      if (commit_i)      state_q[commit_id_i] <= commit_inflight_i ? ID_INFLIGHT : ID_FREE;
      if (result_free_i) state_q[result_id_i] <= ID_FREE;
    end
  end

  // Lowest-numbered free ID and busy count, both from registered state only.
  always_comb begin
    free_valid_o = 1'b0;
    free_id_o    = '0;
    count_o      = '0;
    for (int i = ID_NUM - 1; i >= 0; i--) begin
      if (state_q[i] == ID_FREE) begin
        free_valid_o = 1'b1;
        free_id_o    = X_ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < ID_NUM; i++) begin
      if (state_q[i] != ID_FREE) count_o = count_o + (X_ID_WIDTH + 1)'(1);
    end
  end

  assign query_inflight_o = (state_q[query_id_i] == ID_INFLIGHT);

endmodule

// File: rtl/fir_xif_offloader.sv
// Core-side XIF initiator: captures offload requests into an issue register,
// drives issue/commit, consumes results and produces register-file writebacks.
module fir_xif_offloader #(
  parameter int X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_instr_i,
  input  logic [31:0]           req_rs1_i,
  input  logic [31:0]           req_rs2_i,
  input  logic                  req_kill_i,
  output logic                  x_issue_valid_o,
  input  logic                  x_issue_ready_i,
  output logic [31:0]           x_issue_instr_o,
  output logic [X_ID_WIDTH-1:0] x_issue_id_o,
  output logic [31:0]           x_issue_rs1_o,
  output logic [31:0]           x_issue_rs2_o,
  input  logic                  x_issue_accept_i,
  input  logic                  x_issue_writeback_i,
  output logic                  x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0] x_commit_id_o,
  output logic                  x_commit_kill_o,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0] x_result_id_i,
  input  logic [4:0]            x_result_rd_i,
  input  logic [31:0]           x_result_data_i,
  input  logic                  x_result_we_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic                  illegal_o,
  output logic                  err_o,
  output logic [X_ID_WIDTH:0]   outstanding_o
);
  import fir_xifu_pkg::*;

  offload_req_t          req_p0;
  logic                  vld_p0;
  logic                  commit_vld_p1, illegal_vld_p1, inflight_p1, kill_p1;
  logic [X_ID_WIDTH-1:0] id_p1;
  logic                  wb_vld_p1;
  logic [4:0]            wb_rd_p1;
  logic [31:0]           wb_data_p1;
  logic                  err_q;

  logic                  free_valid, query_inflight;
  logic [X_ID_WIDTH-1:0] free_id;
  logic [X_ID_WIDTH:0]   count;
  logic                  capture, issue_hs, res_hs, res_ok;

  assign issue_hs    = vld_p0 & x_issue_ready_i;
  assign req_ready_o = (~vld_p0 | issue_hs) & free_valid & ~rst_i;
  assign capture     = req_valid_i & req_ready_o;
  assign res_hs      = x_result_valid_i & x_result_ready_o;
  assign res_ok      = res_hs & query_inflight;

  fir_xif_id_alloc #(.X_ID_WIDTH(X_ID_WIDTH)) u_id_alloc (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .reserve_i        (capture),
    .free_valid_o     (free_valid),
    .free_id_o        (free_id),
    .commit_i         (commit_vld_p1 | illegal_vld_p1),
    .commit_id_i      (id_p1),
    .commit_inflight_i(inflight_p1),
    .result_free_i    (res_ok),
    .result_id_i      (x_result_id_i),
    .query_id_i       (x_result_id_i),
    .query_inflight_o (query_inflight),
    .count_o          (count)
  );

  // Stage p0 control: issue register occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i)        vld_p0 <= 1'b0;
    else if (capture) vld_p0 <= 1'b1;
    else if (issue_hs) vld_p0 <= 1'b0;
  end

  // Stage p0 data: captured request payload and allocated ID.
  always_ff @(posedge clk_i) begin
    if (capture) req_p0 <= '{instr: req_instr_i, rs1: req_rs1_i, rs2: req_rs2_i,
                             kill: req_kill_i, id: free_id};
  end

  // Stage p1 control: commit / illegal pulse one cycle after the issue handshake, writeback, sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      commit_vld_p1  <= 1'b0;
      illegal_vld_p1 <= 1'b0;
      wb_vld_p1      <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      commit_vld_p1  <= issue_hs & x_issue_accept_i;
      illegal_vld_p1 <= issue_hs & ~x_issue_accept_i;
      wb_vld_p1      <= res_ok & x_result_we_i & (x_result_rd_i != 5'd0);
      err_q          <= err_q | (res_hs & ~query_inflight);
    end
  end

  // Stage p1 data: commit ID/kill/resolution and writeback payload.
  always_ff @(posedge clk_i) begin
    if (issue_hs) begin
      id_p1       <= req_p0.id;
      kill_p1     <= req_p0.kill;
      inflight_p1 <= x_issue_accept_i & x_issue_writeback_i & ~req_p0.kill;
    end
    if (res_ok) begin
      wb_rd_p1   <= x_result_rd_i;
      wb_data_p1 <= x_result_data_i;
    end
  end

  // Outputs are masked during reset so nothing escapes once rst_i rises.
  assign x_result_ready_o = ~rst_i;
  assign x_issue_valid_o  = vld_p0 & ~rst_i;
  assign x_issue_instr_o  = x_issue_valid_o ? req_p0.instr : '0;
  assign x_issue_rs1_o    = x_issue_valid_o ? req_p0.rs1 : '0;
  assign x_issue_rs2_o    = x_issue_valid_o ? req_p0.rs2 : '0;
  assign x_issue_id_o     = x_issue_valid_o ? req_p0.id : '0;
  assign x_commit_valid_o = commit_vld_p1 & ~rst_i;
  assign x_commit_id_o    = x_commit_valid_o ? id_p1 : '0;
  assign x_commit_kill_o  = x_commit_valid_o & kill_p1;
  assign illegal_o        = illegal_vld_p1 & ~rst_i;
  assign wb_valid_o       = wb_vld_p1 & ~rst_i;
  assign wb_rd_o          = wb_valid_o ? wb_rd_p1 : '0;
  assign wb_data_o        = wb_valid_o ? wb_data_p1 : '0;
  assign err_o            = err_q & ~rst_i;
  assign outstanding_o    = rst_i ? '0 : count;

endmodule
